// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the IF->ID bundle and the default IF/ID buffer depth.
package pipeline_pkg;

  localparam int unsigned PIPE_XLEN       = 32;
  localparam int unsigned IFID_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] pc_plus4;
    logic [PIPE_XLEN-1:0] instr;
  } ifid_t;

endpackage

// File: rtl/ifid_fifo.sv
// Elastic IF->ID buffer: valid/ready on both sides, flush discards everything
// fetched but not yet decoded. Flags come only from the registered pointers,
// so there is no combinational path from in_valid/out_ready to any output.
module ifid_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN  = PIPE_XLEN,
  parameter int unsigned DEPTH = IFID_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  ifid_t                      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output ifid_t                      out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  // Raw storage width is tied to XLEN; the cast on read requires it to match ifid_t.
  typedef logic [3*XLEN-1:0] entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] diff;
  logic             empty, full;
  logic             push, pop, wr_en;

  // Status flags and outputs derived purely from the pointer registers.
  always_comb begin
    empty     = (wptr_q == rptr_q);
    full      = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);
    out_valid = !empty;
    in_ready  = !full;
    diff      = wptr_q - rptr_q;
    count     = diff[CNT_W-1:0];
    out_data  = ifid_t'(mem_q[rptr_q[IDX_W-1:0]]);
  end

  // Pointer next-state; flush wins and silently drops a coincident push.
  always_comb begin
    push   = in_valid && !full;
    pop    = !empty && out_ready;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    wr_en  = 1'b0;
    if (flush) begin
      rptr_d = wptr_q;
    end else begin
      if (push) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
    end
  end

  // Pointer registers; wrap bit overflows naturally modulo 2*DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; cleared on reset so the head read is never X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wptr_q[IDX_W-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_ifid_fifo.sv
// Directed + random bench for ifid_fifo against a queue-based reference model.
module tb_ifid_fifo;
  import pipeline_pkg::*;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  ifid_t      in_data;
  logic       out_valid;
  logic       out_ready;
  ifid_t      out_data;
  logic       flush;
  logic [1:0] count;

  int vectors = 0;
  int miscompares = 0;
  ifid_t model[$];
  ifid_t upstream[$];

  ifid_fifo #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  function automatic ifid_t mk(input logic [31:0] pc, input logic [31:0] ins);
    ifid_t b;
    b.pc = pc;
    b.pc_plus4 = pc + 32'd4;
    b.instr = ins;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the registered outputs against the model, apply one cycle, update the model.
  task automatic cycle(input logic iv, input ifid_t d, input logic ordy, input logic fl,
                       output logic pushed);
    logic popped;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    chk("in_ready", 96'(in_ready), 96'(model.size() < DEPTH));
    chk("out_valid", 96'(out_valid), 96'(model.size() != 0));
    chk("count", 96'(count), 96'(model.size()));
    chk("count_bound", 96'(int'(count) <= DEPTH), 96'(1));
    if (model.size() != 0) chk("out_data", out_data, model[0]);
    pushed = iv && (model.size() < DEPTH);
    popped = ordy && (model.size() != 0);
    @(posedge clk);
    if (fl) begin
      model.delete();
    end else begin
      if (popped) void'(model.pop_front());
      if (pushed) model.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    logic p;
    ifid_t d;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset/idle: empty, ready, head reads zero.
    chk("reset_out_data", out_data, 96'(0));
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, p);

    // Single push then pop.
    cycle(1'b1, mk(32'h0, 32'h0050_0093), 1'b0, 1'b0, p);
    cycle(1'b0, '0, 1'b0, 1'b0, p);
    cycle(1'b0, '0, 1'b1, 1'b0, p);
    cycle(1'b0, '0, 1'b0, 1'b0, p);

    // Three bundles into a 2-deep buffer: third held upstream until space frees.
    for (int i = 0; i < 3; i++) upstream.push_back(mk(32'(i * 4), $urandom));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, upstream[0], 1'b0, 1'b0, p);
      if (p) void'(upstream.pop_front());
    end
    for (int i = 0; i < 8 && (upstream.size() != 0 || model.size() != 0); i++) begin
      if (upstream.size() != 0) begin
        d = upstream[0];
        cycle(1'b1, d, 1'b1, 1'b0, p);
        if (p) void'(upstream.pop_front());
      end else begin
        cycle(1'b0, '0, 1'b1, 1'b0, p);
      end
    end
    chk("drain_done", 96'(upstream.size() + model.size()), 96'(0));

    // Streaming with both sides ready; 10 pushes wrap the pointers twice.
    for (int i = 0; i < 10; i++) cycle(1'b1, mk(32'(i * 4), $urandom), 1'b1, 1'b0, p);
    cycle(1'b0, '0, 1'b1, 1'b0, p);
    cycle(1'b0, '0, 1'b0, 1'b0, p);

    // Fill, then flush with a coincident push of 0x40 (dropped); 0x80 emerges next.
    cycle(1'b1, mk(32'h10, $urandom), 1'b0, 1'b0, p);
    cycle(1'b1, mk(32'h14, $urandom), 1'b0, 1'b0, p);
    cycle(1'b1, mk(32'h40, $urandom), 1'b0, 1'b1, p);
    cycle(1'b1, mk(32'h80, 32'h0000_0013), 1'b0, 1'b0, p);
    cycle(1'b0, '0, 1'b1, 1'b0, p);
    cycle(1'b0, '0, 1'b0, 1'b0, p);

    // Async reset mid-cycle with the buffer full.
    cycle(1'b1, mk(32'h100, $urandom), 1'b0, 1'b0, p);
    cycle(1'b1, mk(32'h104, $urandom), 1'b0, 1'b0, p);
    in_valid = 1'b1; out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", 96'(out_valid), 96'(0));
    chk("async_count", 96'(count), 96'(0));
    chk("async_in_ready", 96'(in_ready), 96'(1));
    chk("async_out_data", out_data, 96'(0));
    model.delete();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, mk(32'h200, $urandom), 1'b0, 1'b0, p);
    cycle(1'b0, '0, 1'b1, 1'b0, p);
    cycle(1'b0, '0, 1'b0, 1'b0, p);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, mk($urandom, $urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifid_fifo.md
Name: ifid_fifo

Overview:
- Small elastic buffer between the fetch stage and the decode stage; holds `ifid_t` bundles (PC, PCPlus4, instr).
- Decouples fetch from decode back-pressure with a valid/ready handshake on each side.
- Accepts a flush from the redirect logic that discards all fetched-but-undecoded instructions.
- Lives in `rtl/stages/`, instantiated between the IF stage outputs and the ID stage inputs.

Parameters:
- XLEN, 32, datapath width; must match `ifid_t` field widths.
- DEPTH, 2, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents a valid bundle.
- in_ready  output  1  buffer can accept a bundle this cycle.
- in_data  input  ifid_t  bundle from the IF stage.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_data  output  ifid_t  head entry.
- flush  input  1  discard all contents (branch/jump redirect).
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: DEPTH-entry register array of `ifid_t`.
  - Write pointer wptr and read pointer rptr, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Reset (async, active-high):
  - wptr=0, rptr=0, all storage entries=0.
  - Outputs after reset: out_valid=0, in_ready=1, count=0, out_data=0.
- Flags and outputs:
  - empty = (wptr==rptr).
  - full = (index bits equal) and (wrap bits differ).
  - out_valid = !empty; in_ready = !full. Both are purely registered-state functions, with no combinational path from in_valid or out_ready.
  - out_data = storage[rptr index], combinational read. When empty the value is don't-care, but it is X-free because storage resets to 0.
- Handshakes:
  - Push occurs when in_valid && in_ready: the entry is written and wptr increments on the same edge.
  - Pop occurs when out_valid && out_ready: rptr increments.
  - Latency: a bundle pushed in cycle N is visible on out_data with out_valid=1 in cycle N+1 (one-cycle minimum latency, no bypass).
- Simultaneous push and pop:
  - Legal whenever not full and not empty; count is unchanged.
  - When full, in_ready=0, so no push occurs even if a pop happens that cycle. in_ready rises the cycle after the pop.
  - When empty, a push proceeds; no pop is possible.
- Flush (synchronous, highest priority):
  - On an edge with flush=1: rptr<=wptr, so the buffer empties and count becomes 0.
  - A push coincident with flush is dropped (in_ready is not gated; the entry is simply discarded).
  - A pop coincident with flush is irrelevant.
  - Storage contents are not cleared.
  - The next cycle shows out_valid=0.
- Wrap-around: pointers increment modulo 2*DEPTH via natural overflow of the extra wrap bit.
- count = wptr - rptr, truncated to the count width.
- Reset asserted mid-operation: immediate return to the reset state regardless of handshake activity. In-flight bundles are lost.
- Invariants (assert in bench):
  - count <= DEPTH.
  - No push when full.
  - No pop when empty.
  - out_data stable while out_valid && !out_ready && !flush.

Decomposition:
- `pipeline_pkg`: reuse `ifid_t`. Add `localparam IFID_FIFO_DEPTH = 2` for top-level instantiation.
- No sub-module. Storage and pointer logic are flat in one module (~150 lines).

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, count=0 for 5 cycles.
- Single push {PC=0x00, PCPlus4=0x04, instr=0x00500093} with out_ready=0 → next cycle out_valid=1, out_data matches, count=1. Assert out_ready → count=0 the following cycle.
- Push 3 bundles (PC 0x00, 0x04, 0x08) with out_ready=0, DEPTH=2:
  - After 2 pushes, in_ready=0 and count=2; third bundle held upstream.
  - Then out_ready=1 → pops 0x00, 0x04, then 0x08, in order.
- Streaming with in_valid=out_ready=1 for 10 cycles (PC 0x00..0x24):
  - count holds at 1 after the first cycle.
  - Pointers wrap at least twice.
  - Output order matches input, no loss or duplication.
- Full buffer plus flush=1 coincident with in_valid=1 (PC=0x40):
  - Next cycle count=0, out_valid=0.
  - Bundle 0x40 never appears; the subsequent push of 0x80 emerges first.
- Async reset pulsed mid-cycle while count=2 → out_valid=0 and count=0 immediately, before the next clock edge. Operation resumes normally after release.
